// File: rtl/id_ex_pipe_stage_if.sv
// rtl/id_ex_pipe_stage_if.sv - ID->EX stage bus: upstream beat, downstream registered beat and handshakes
interface id_ex_pipe_stage_if #(
  parameter int XLEN  = 32,
  parameter int EX_W  = 2,
  parameter int MEM_W = 3,
  parameter int WB_W  = 2
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      inst_i;
  logic [XLEN-1:0]  rs_data_i;
  logic [XLEN-1:0]  rt_data_i;
  logic [EX_W-1:0]  ex_sig_i;
  logic [MEM_W-1:0] mem_sig_i;
  logic [WB_W-1:0]  wb_sig_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      inst_o;
  logic [XLEN-1:0]  rs_data_o;
  logic [XLEN-1:0]  rt_data_o;
  logic [XLEN-1:0]  imm_o;
  logic [XLEN-1:0]  op_b_o;
  logic [EX_W-1:0]  ex_sig_o;
  logic [MEM_W-1:0] mem_sig_o;
  logic [WB_W-1:0]  wb_sig_o;

  modport slave (
    input  in_valid_i, inst_i, rs_data_i, rt_data_i, ex_sig_i, mem_sig_i, wb_sig_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, rs_data_o, rt_data_o, imm_o, op_b_o,
           ex_sig_o, mem_sig_o, wb_sig_o
  );

  modport master (
    output in_valid_i, inst_i, rs_data_i, rt_data_i, ex_sig_i, mem_sig_i, wb_sig_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, rs_data_o, rt_data_o, imm_o, op_b_o,
           ex_sig_o, mem_sig_o, wb_sig_o
  );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - ID->EX pipeline register with valid/ready, stall hold, flush and imm/op_b decode
// Optional ID_EX_SKID_EN: one-entry skid buffer so in_ready_o comes from a flop.
module id_ex_pipe_stage #(
  parameter int          XLEN  = 32,
  parameter int          EX_W  = 2,
  parameter int          MEM_W = 3,
  parameter int          WB_W  = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input logic               clk_i,
  input logic               rst_n_i,
  input logic               flush_i,
  id_ex_pipe_stage_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             valid_q, valid_d;
  logic [31:0]      inst_q, inst_d;
  logic [XLEN-1:0]  rs_q, rs_d, rt_q, rt_d, imm_q, imm_d, op_b_q, op_b_d;
  logic [EX_W-1:0]  ex_q, ex_d;
  logic [MEM_W-1:0] mem_q, mem_d;
  logic [WB_W-1:0]  wb_q, wb_d;

  logic             main_free, accept, load_main;
  logic [31:0]      src_inst;
  logic [XLEN-1:0]  src_rs, src_rt, src_imm;
  logic [EX_W-1:0]  src_ex;
  logic [MEM_W-1:0] src_mem;
  logic [WB_W-1:0]  src_wb;
  logic             src_use_imm;

  assign main_free = !valid_q || bus.out_ready_i;

`ifdef ID_EX_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [31:0]      skid_inst_q, skid_inst_d;
  logic [XLEN-1:0]  skid_rs_q, skid_rs_d, skid_rt_q, skid_rt_d;
  logic [EX_W-1:0]  skid_ex_q, skid_ex_d;
  logic [MEM_W-1:0] skid_mem_q, skid_mem_d;
  logic [WB_W-1:0]  skid_wb_q, skid_wb_d;

  assign bus.in_ready_o = !skid_valid_q;
  assign accept         = bus.in_valid_i && !skid_valid_q;
  // A parked beat is always older than anything upstream, so it refills main first.
  assign load_main      = main_free && (skid_valid_q || accept);
  assign src_inst       = skid_valid_q ? skid_inst_q : bus.inst_i;
  assign src_rs         = skid_valid_q ? skid_rs_q   : bus.rs_data_i;
  assign src_rt         = skid_valid_q ? skid_rt_q   : bus.rt_data_i;
  assign src_ex         = skid_valid_q ? skid_ex_q   : bus.ex_sig_i;
  assign src_mem        = skid_valid_q ? skid_mem_q  : bus.mem_sig_i;
  assign src_wb         = skid_valid_q ? skid_wb_q   : bus.wb_sig_i;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_rs_d    = skid_rs_q;
    skid_rt_d    = skid_rt_q;
    skid_ex_d    = skid_ex_q;
    skid_mem_d   = skid_mem_q;
    skid_wb_d    = skid_wb_q;
    if (flush_i) begin
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && main_free) begin
      skid_valid_d = 1'b0;
    end else if (accept && !main_free) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = bus.inst_i;
      skid_rs_d    = bus.rs_data_i;
      skid_rt_d    = bus.rt_data_i;
      skid_ex_d    = bus.ex_sig_i;
      skid_mem_d   = bus.mem_sig_i;
      skid_wb_d    = bus.wb_sig_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_rs_q    <= '0;
      skid_rt_q    <= '0;
      skid_ex_q    <= '0;
      skid_mem_q   <= '0;
      skid_wb_q    <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_rs_q    <= skid_rs_d;
      skid_rt_q    <= skid_rt_d;
      skid_ex_q    <= skid_ex_d;
      skid_mem_q   <= skid_mem_d;
      skid_wb_q    <= skid_wb_d;
    end
  end
`else
  assign bus.in_ready_o = main_free;
  assign accept         = bus.in_valid_i && main_free;
  assign load_main      = accept;
  assign src_inst       = bus.inst_i;
  assign src_rs         = bus.rs_data_i;
  assign src_rt         = bus.rt_data_i;
  assign src_ex         = bus.ex_sig_i;
  assign src_mem        = bus.mem_sig_i;
  assign src_wb         = bus.wb_sig_i;
`endif

  always_comb begin
    src_imm     = '0;
    src_use_imm = 1'b0;
    case (src_inst[6:0])
      OP_LOAD, OP_IMM: begin
        src_imm     = {{(XLEN-12){src_inst[31]}}, src_inst[31:20]};
        src_use_imm = 1'b1;
      end
      OP_STORE: begin
        src_imm     = {{(XLEN-12){src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
        src_use_imm = 1'b1;
      end
      OP_BRANCH: begin
        src_imm = {{(XLEN-13){src_inst[31]}}, src_inst[31], src_inst[7],
                   src_inst[30:25], src_inst[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // Flush outranks both capture and drain; data registers are left as-is on a bubble.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    op_b_d  = op_b_q;
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_main) begin
      valid_d = 1'b1;
      inst_d  = src_inst;
      rs_d    = src_rs;
      rt_d    = src_rt;
      imm_d   = src_imm;
      op_b_d  = src_use_imm ? src_imm : src_rt;
      ex_d    = src_ex;
      mem_d   = src_mem;
      wb_d    = src_wb;
    end else if (bus.out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      op_b_q  <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      op_b_q  <= op_b_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.out_valid_o = valid_q;
  assign bus.inst_o      = valid_q ? inst_q : NOP;
  assign bus.rs_data_o   = rs_q;
  assign bus.rt_data_o   = rt_q;
  assign bus.imm_o       = imm_q;
  assign bus.op_b_o      = op_b_q;
  assign bus.ex_sig_o    = valid_q ? ex_q  : '0;
  assign bus.mem_sig_o   = valid_q ? mem_q : '0;
  assign bus.wb_sig_o    = valid_q ? wb_q  : '0;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb/tb_id_ex_pipe_stage.sv - self-checking bench for id_ex_pipe_stage against a queue-level model
module tb_id_ex_pipe_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage_if #(.XLEN(32), .EX_W(2), .MEM_W(3), .WB_W(2)) bus ();

  id_ex_pipe_stage dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [1:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb;
  } beat_t;

  beat_t       q[$];
  logic [31:0] got[$];
  logic [31:0] inst_tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediate from the ISA field layout, built with integer arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    logic [6:0] opc;
    opc = w[6:0];
    v = 0;
    case (opc)
      7'h03, 7'h13: begin
        v = int'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_op_b(input logic [31:0] w, input logic [31:0] rt);
    logic [6:0] opc;
    opc = w[6:0];
    return (opc == 7'h03 || opc == 7'h13 || opc == 7'h23) ? ref_imm(w) : rt;
  endfunction

  function automatic int model_ready();
`ifdef ID_EX_SKID_EN
    return (q.size() < 2) ? 1 : 0;
`else
    return (q.size() == 0 || bus.out_ready_i) ? 1 : 0;
`endif
  endfunction

  logic         hold_v = 1'b0;
  logic [166:0] snap;
  logic [166:0] cur;

  always @(negedge clk) begin
    cur = {bus.inst_o, bus.rs_data_o, bus.rt_data_o, bus.imm_o, bus.op_b_o,
           bus.ex_sig_o, bus.mem_sig_o, bus.wb_sig_o};
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
      chk("rst_valid", 32'(bus.out_valid_o), 0);
      chk("rst_inst", bus.inst_o, NOP);
      chk("rst_imm", bus.imm_o, 0);
      chk("rst_op_b", bus.op_b_o, 0);
      chk("rst_rs", bus.rs_data_o, 0);
      chk("rst_ctrl", 32'({bus.ex_sig_o, bus.mem_sig_o, bus.wb_sig_o}), 0);
    end else begin
      chk("out_valid", 32'(bus.out_valid_o), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready_o), 32'(model_ready()));
      if (q.size() != 0) begin
        chk("inst", bus.inst_o, q[0].inst);
        chk("rs_data", bus.rs_data_o, q[0].rs);
        chk("rt_data", bus.rt_data_o, q[0].rt);
        chk("imm", bus.imm_o, ref_imm(q[0].inst));
        chk("op_b", bus.op_b_o, ref_op_b(q[0].inst, q[0].rt));
        chk("ctrl", 32'({bus.ex_sig_o, bus.mem_sig_o, bus.wb_sig_o}),
            32'({q[0].ex, q[0].mem, q[0].wb}));
      end else begin
        chk("bubble_inst", bus.inst_o, NOP);
        chk("bubble_ctrl", 32'({bus.ex_sig_o, bus.mem_sig_o, bus.wb_sig_o}), 0);
      end
      if (hold_v) begin
        vectors++;
        if (cur !== snap) begin
          miscompares++;
          $display("FAIL stall_hold: got %h expected %h at %0t", cur, snap, $time);
        end
      end
      hold_v = (q.size() != 0) && !bus.out_ready_i && !flush;
      snap = cur;
      if (q.size() != 0 && bus.out_ready_i) got.push_back(q[0].rs);
      if (flush) begin
        q.delete();
      end else begin
        beat_t b;
        if (q.size() != 0 && bus.out_ready_i) void'(q.pop_front());
        if (bus.in_valid_i && model_ready() != 0) begin
          b.inst = bus.inst_i;
          b.rs   = bus.rs_data_i;
          b.rt   = bus.rt_data_i;
          b.ex   = bus.ex_sig_i;
          b.mem  = bus.mem_sig_i;
          b.wb   = bus.wb_sig_i;
          q.push_back(b);
        end
      end
    end
  end

  task automatic set_beat(input int k, input logic [31:0] inst, input logic [31:0] rt);
    bus.in_valid_i = 1'b1;
    bus.inst_i     = inst;
    bus.rs_data_i  = 32'(k);
    bus.rt_data_i  = rt;
    bus.ex_sig_i   = 2'(k);
    bus.mem_sig_i  = 3'(k + 3);
    bus.wb_sig_i   = 2'(k + 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input logic [15:0] rdy, output int cycles);
    int idx;
    int c;
    idx = 0;
    c = 0;
    got.delete();
    while ((idx < n || q.size() != 0) && c < 200) begin
      bus.out_ready_i = (idx < n) ? rdy[c % 16] : 1'b1;
      if (idx < n) set_beat(idx + 1, inst_tab[idx % inst_tab.size()], 32'hA000_0000 + 32'(idx));
      else bus.in_valid_i = 1'b0;
      @(negedge clk);
      if (bus.in_valid_i && bus.in_ready_o) idx++;
      step();
      c++;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    cycles = c;
    chk("stream_budget", 32'(c < 200), 1);
    chk("stream_count", 32'(got.size()), 32'(n));
    for (int i = 0; i < got.size() && i < n; i++) chk("stream_order", got[i], 32'(i + 1));
  endtask

  task automatic drain();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    flush = 1'b0;
    repeat (3) step();
  endtask

  int cyc;

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.inst_i      = '0;
    bus.rs_data_i   = '0;
    bus.rt_data_i   = '0;
    bus.ex_sig_i    = '0;
    bus.mem_sig_i   = '0;
    bus.wb_sig_i    = '0;
    inst_tab = '{32'h0050_0093, 32'hFFC0_A083, 32'hFE51_2E23, 32'hFE20_8EE3, 32'h0020_81B3, 32'h8000_0113};
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Immediates pinned by hand: store and beq both encode -4.
    bus.out_ready_i = 1'b0;
    set_beat(7, 32'hFE51_2E23, 32'h1111_2222);
    step();
    chk("lit_store_imm", bus.imm_o, 32'hFFFF_FFFC);
    chk("lit_store_op_b", bus.op_b_o, 32'hFFFF_FFFC);
    bus.out_ready_i = 1'b1;
    set_beat(8, 32'hFE20_8EE3, 32'h1234_5678);
    step();
    chk("lit_beq_imm", bus.imm_o, 32'hFFFF_FFFC);
    chk("lit_beq_op_b", bus.op_b_o, 32'h1234_5678);
    chk("lit_beq_valid", 32'(bus.out_valid_o), 1);
    drain();

    // Back-to-back: one beat per cycle, last beat drains one cycle after its accept.
    stream(6, 16'hFFFF, cyc);
    chk("b2b_cycles", 32'(cyc), 7);
    drain();

    // Three-cycle downstream stall mid-stream.
    stream(5, 16'hFF8F, cyc);
    drain();
    stream(5, 16'hAAAA, cyc);
    drain();
    stream(8, 16'h3333, cyc);
    drain();

`ifdef ID_EX_SKID_EN
    bus.out_ready_i = 1'b0;
    set_beat(1, 32'h0050_0093, 0);
    step();
    set_beat(2, 32'h0050_0093, 0);
    step();
    chk("skid_ready_low", 32'(bus.in_ready_o), 0);
    bus.out_ready_i = 1'b1;
    #1;
    chk("skid_ready_no_comb", 32'(bus.in_ready_o), 0);
    bus.in_valid_i = 1'b0;
    step();
    chk("skid_ready_back", 32'(bus.in_ready_o), 1);
    drain();
`endif

    // Flush while stalled and offering a new beat.
    bus.out_ready_i = 1'b0;
    set_beat(3, 32'h0050_0093, 0);
    step();
    flush = 1'b1;
    set_beat(4, 32'hFE51_2E23, 0);
    step();
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("lit_flush_valid", 32'(bus.out_valid_o), 0);
    chk("lit_flush_ctrl", 32'({bus.ex_sig_o, bus.mem_sig_o, bus.wb_sig_o}), 0);
    chk("lit_flush_inst", bus.inst_o, NOP);
    drain();

    // Asynchronous reset in the middle of a held beat.
    bus.out_ready_i = 1'b0;
    set_beat(5, 32'hFFC0_A083, 0);
    step();
    chk("lit_pre_rst_valid", 32'(bus.out_valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_rst_valid", 32'(bus.out_valid_o), 0);
    chk("lit_rst_inst", bus.inst_o, 32'h0000_0013);
    chk("lit_rst_ctrl", 32'({bus.ex_sig_o, bus.mem_sig_o, bus.wb_sig_o}), 0);
    bus.in_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("lit_post_rst_ready", 32'(bus.in_ready_o), 1);
    stream(4, 16'hF0F0, cyc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
